// File: rtl/decode_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the decode/forwarding slice:
//   - opcode constants and class range bounds
//   - instruction field bit positions
//   - forwarding select encodings
//   - dest_t: one slot of the issued-destination shift chain
//   - classify(): maps a raw opcode to its decode class
// ---------------------------------------------------------------------------
package decode_pkg;

    localparam int OP_W  = 6;
    localparam int REG_W = 5;

    // Instruction field positions
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RW_MSB  = 25;
    localparam int RW_LSB  = 21;
    localparam int RA_MSB  = 20;
    localparam int RA_LSB  = 16;
    localparam int RB_MSB  = 15;
    localparam int RB_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // Opcode constants and class bounds
    localparam logic [OP_W-1:0] OP_NOP  = 6'h00;
    localparam logic [OP_W-1:0] OP_R_LO = 6'h01;
    localparam logic [OP_W-1:0] OP_R_HI = 6'h1F;
    localparam logic [OP_W-1:0] OP_I_LO = 6'h20;
    localparam logic [OP_W-1:0] OP_I_HI = 6'h2F;
    localparam logic [OP_W-1:0] OP_LOAD = 6'h30;

    // Operand source selects consumed by the register bank
    localparam logic [1:0] SEL_BANK = 2'b00;
    localparam logic [1:0] SEL_EX   = 2'b01;
    localparam logic [1:0] SEL_DM   = 2'b10;
    localparam logic [1:0] SEL_WB   = 2'b11;

    typedef struct packed {
        logic [REG_W-1:0] dest;
        logic             wen;
        logic             load;
    } dest_t;

    typedef enum logic [1:0] {
        CLS_NOP  = 2'd0,
        CLS_R    = 2'd1,
        CLS_I    = 2'd2,
        CLS_LOAD = 2'd3
    } op_class_t;

    // Any opcode outside the defined ranges is treated as a NOP.
    function automatic op_class_t classify(input logic [OP_W-1:0] op);
        op_class_t cls;
        cls = CLS_NOP;
        if (op >= OP_R_LO && op <= OP_R_HI) begin
            cls = CLS_R;
        end else if (op >= OP_I_LO && op <= OP_I_HI) begin
            cls = CLS_I;
        end else if (op == OP_LOAD) begin
            cls = CLS_LOAD;
        end
        return cls;
    endfunction

endpackage

// File: rtl/decode_forward_unit_fwd_select.sv
// ---------------------------------------------------------------------------
// fwd_select
// Chooses where one source operand should come from, given the three most
// recently issued destinations (d1 youngest).
// Ports:
//   src     in   source register address
//   used    in   the instruction actually reads this source
//   d1..d3  in   issued-destination slots (d1 = EX, d2 = DM, d3 = WB)
//   sel     out  SEL_BANK / SEL_EX / SEL_DM / SEL_WB
// ---------------------------------------------------------------------------
module fwd_select
    import decode_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic             used,
    input  dest_t            d1,
    input  dest_t            d2,
    input  dest_t            d3,
    output logic [1:0]       sel
);

    // The load flag only matters for stall detection, not selection.
    logic unused_load;
    assign unused_load = d1.load ^ d2.load ^ d3.load;

    // Youngest producer wins; register 0 is a sink and never forwarded.
    always_comb begin
        sel = SEL_BANK;
        if (used && (src != '0)) begin
            if (d1.wen && (d1.dest == src)) begin
                sel = SEL_EX;
            end else if (d2.wen && (d2.dest == src)) begin
                sel = SEL_DM;
            end else if (d3.wen && (d3.dest == src)) begin
                sel = SEL_WB;
            end
        end
    end

endmodule

// File: rtl/decode_forward_unit.sv
// ---------------------------------------------------------------------------
// decode_forward_unit
// Decode/issue stage in front of the register bank. Holds one instruction in
// the ID register, drives the bank read addresses, tracks the destinations of
// the last three issue slots and produces forwarding selects, immediate and
// imm_sel aligned with the bank read data. A load followed by a dependent
// instruction costs one bubble.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   instr, instr_valid  incoming instruction and its valid
//   instr_ready         unit accepts instr this cycle (low only while stalled)
//   RA, RB              bank read addresses from the ID register
//   RW_dm               bank write address of the slot writing back now
//   mux_sel_A/B         forwarding selects for operands A/B
//   imm_sel, imm        operand B takes imm
//   op_ex               opcode of the instruction now using A/B (0 = bubble)
// ---------------------------------------------------------------------------
module decode_forward_unit
    import decode_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 5,
    parameter int IW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IW-1:0]   instr,
    input  logic            instr_valid,
    output logic            instr_ready,
    output logic [AW-1:0]   RA,
    output logic [AW-1:0]   RB,
    output logic [AW-1:0]   RW_dm,
    output logic [1:0]      mux_sel_A,
    output logic [1:0]      mux_sel_B,
    output logic            imm_sel,
    output logic [DW-1:0]   imm,
    output logic [OP_W-1:0] op_ex
);

    // ID register and destination chain
    logic            id_valid_reg, id_valid_next;
    logic [IW-1:0]   id_instr_reg, id_instr_next;
    dest_t           d1_reg, d2_reg, d3_reg, d1_next;

    // Issue-aligned outputs
    logic [1:0]      mux_sel_a_reg, mux_sel_a_next;
    logic [1:0]      mux_sel_b_reg, mux_sel_b_next;
    logic            imm_sel_reg, imm_sel_next;
    logic [DW-1:0]   imm_reg, imm_next;
    logic [OP_W-1:0] op_ex_reg, op_ex_next;

    // Decode of the instruction sitting in ID
    logic [OP_W-1:0]  id_op;
    logic [REG_W-1:0] id_rw;
    op_class_t        id_cls;
    logic             id_writes, id_reads_b, id_is_imm, id_is_load;

    assign id_op      = id_instr_reg[OP_MSB:OP_LSB];
    assign id_rw      = id_instr_reg[RW_MSB:RW_LSB];
    assign id_cls     = classify(id_op);
    assign id_writes  = (id_cls != CLS_NOP);
    assign id_reads_b = (id_cls == CLS_R);
    assign id_is_imm  = (id_cls == CLS_I) || (id_cls == CLS_LOAD);
    assign id_is_load = (id_cls == CLS_LOAD);

    // Source 0 = A (ra), source 1 = B (rb). Every writing class reads ra.
    logic [REG_W-1:0] src_addr [2];
    logic [1:0]       src_used;
    logic [1:0]       src_sel [2];
    logic [1:0]       src_hazard;

    assign src_addr[0] = id_instr_reg[RA_MSB:RA_LSB];
    assign src_addr[1] = id_instr_reg[RB_MSB:RB_LSB];
    assign src_used    = {id_reads_b, id_writes};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            fwd_select u_fwd_select (
                .src  (src_addr[gi]),
                .used (src_used[gi]),
                .d1   (d1_reg),
                .d2   (d2_reg),
                .d3   (d3_reg),
                .sel  (src_sel[gi])
            );
            assign src_hazard[gi] = src_used[gi] && (d1_reg.dest == src_addr[gi]);
        end
    endgenerate

    // A load result is not available from EX, so a consumer right behind it
    // waits one cycle and then picks it up from DM.
    logic stall, issue, accept;

    assign stall  = id_valid_reg && d1_reg.load && d1_reg.wen &&
                    (d1_reg.dest != '0) && (|src_hazard);
    assign issue  = id_valid_reg && !stall;
    assign accept = instr_valid && instr_ready;

    assign instr_ready = !stall;

    always_comb begin
        id_valid_next  = id_valid_reg;
        id_instr_next  = id_instr_reg;
        d1_next        = '0;
        mux_sel_a_next = SEL_BANK;
        mux_sel_b_next = SEL_BANK;
        imm_sel_next   = 1'b0;
        imm_next       = '0;
        op_ex_next     = OP_NOP;

        if (accept) begin
            id_valid_next = 1'b1;
            id_instr_next = instr;
        end else if (issue) begin
            id_valid_next = 1'b0;
        end

        if (issue) begin
            d1_next.dest   = id_rw;
            d1_next.wen    = id_writes;
            d1_next.load   = id_is_load;
            mux_sel_a_next = src_sel[0];
            mux_sel_b_next = src_sel[1];
            imm_sel_next   = id_is_imm;
            imm_next       = id_instr_reg[IMM_MSB:IMM_LSB];
            // Undefined opcodes travel down as plain NOPs.
            op_ex_next     = id_writes ? id_op : OP_NOP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_reg  <= 1'b0;
            id_instr_reg  <= '0;
            d1_reg        <= '0;
            d2_reg        <= '0;
            d3_reg        <= '0;
            mux_sel_a_reg <= SEL_BANK;
            mux_sel_b_reg <= SEL_BANK;
            imm_sel_reg   <= 1'b0;
            imm_reg       <= '0;
            op_ex_reg     <= OP_NOP;
        end else begin
            id_valid_reg  <= id_valid_next;
            id_instr_reg  <= id_instr_next;
            // The chain always shifts; non-issue cycles inject a bubble.
            d1_reg        <= d1_next;
            d2_reg        <= d1_reg;
            d3_reg        <= d2_reg;
            mux_sel_a_reg <= mux_sel_a_next;
            mux_sel_b_reg <= mux_sel_b_next;
            imm_sel_reg   <= imm_sel_next;
            imm_reg       <= imm_next;
            op_ex_reg     <= op_ex_next;
        end
    end

    assign RA        = id_valid_reg ? src_addr[0] : '0;
    assign RB        = id_valid_reg ? src_addr[1] : '0;
    assign RW_dm     = d3_reg.wen ? d3_reg.dest : '0;
    assign mux_sel_A = mux_sel_a_reg;
    assign mux_sel_B = mux_sel_b_reg;
    assign imm_sel   = imm_sel_reg;
    assign imm       = imm_reg;
    assign op_ex     = op_ex_reg;

endmodule

// File: tb/tb_decode_forward_unit.sv
// ---------------------------------------------------------------------------
// tb_decode_forward_unit
// Directed scenarios followed by a randomized run. The reference model keeps
// the raw instructions in flight (ID plus the last three issue slots) and
// derives every expected output from opcode ranges and register fields.
// ---------------------------------------------------------------------------
module tb_decode_forward_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  RA, RB, RW_dm;
    logic [1:0]  mux_sel_A, mux_sel_B;
    logic        imm_sel;
    logic [15:0] imm;
    logic [5:0]  op_ex;

    decode_forward_unit #(.DW(16), .AW(5), .IW(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .RA          (RA),
        .RB          (RB),
        .RW_dm       (RW_dm),
        .mux_sel_A   (mux_sel_A),
        .mux_sel_B   (mux_sel_B),
        .imm_sel     (imm_sel),
        .imm         (imm),
        .op_ex       (op_ex)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    logic        m_id_valid;
    logic [31:0] m_id;
    logic [31:0] m_slot [3];   // 0 = most recently issued; bubble = 32'h0
    logic [1:0]  e_sel_a, e_sel_b;
    logic        e_imm_sel;
    logic [15:0] e_imm;
    logic [5:0]  e_op_ex;

    function automatic logic [5:0] opc(input logic [31:0] x);
        return x[31:26];
    endfunction
    function automatic logic [4:0] f_rw(input logic [31:0] x);
        return x[25:21];
    endfunction
    function automatic logic [4:0] f_ra(input logic [31:0] x);
        return x[20:16];
    endfunction
    function automatic logic [4:0] f_rb(input logic [31:0] x);
        return x[15:11];
    endfunction
    function automatic bit f_writes(input logic [31:0] x);
        return opc(x) >= 6'h01 && opc(x) <= 6'h30;
    endfunction
    function automatic bit f_reads_b(input logic [31:0] x);
        return opc(x) >= 6'h01 && opc(x) <= 6'h1F;
    endfunction
    function automatic bit f_imm(input logic [31:0] x);
        return opc(x) >= 6'h20 && opc(x) <= 6'h30;
    endfunction
    function automatic bit f_load(input logic [31:0] x);
        return opc(x) == 6'h30;
    endfunction

    // Distance (1..3) to the youngest in-flight writer of s, 0 if none.
    function automatic logic [1:0] fwd(input logic [4:0] s, input bit used);
        if (!used || s == 5'd0) return 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (f_writes(m_slot[k]) && f_rw(m_slot[k]) == s) return 2'(k + 1);
        end
        return 2'd0;
    endfunction

    function automatic bit m_stall();
        logic [4:0] ld;
        ld = f_rw(m_slot[0]);
        if (!m_id_valid || !f_load(m_slot[0]) || ld == 5'd0) return 1'b0;
        return (f_writes(m_id) && ld == f_ra(m_id)) ||
               (f_reads_b(m_id) && ld == f_rb(m_id));
    endfunction

    task automatic model_reset();
        m_id_valid = 1'b0;
        m_id       = 32'h0;
        for (int k = 0; k < 3; k++) m_slot[k] = 32'h0;
        e_sel_a    = 2'd0;
        e_sel_b    = 2'd0;
        e_imm_sel  = 1'b0;
        e_imm      = 16'h0;
        e_op_ex    = 6'h0;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [4:0] e_ra, e_rb, e_rw;
        e_ra = m_id_valid ? f_ra(m_id) : 5'd0;
        e_rb = m_id_valid ? f_rb(m_id) : 5'd0;
        e_rw = f_writes(m_slot[2]) ? f_rw(m_slot[2]) : 5'd0;
        chk("instr_ready", 32'(instr_ready), 32'(!m_stall()));
        chk("RA",          32'(RA),          32'(e_ra));
        chk("RB",          32'(RB),          32'(e_rb));
        chk("RW_dm",       32'(RW_dm),       32'(e_rw));
        chk("mux_sel_A",   32'(mux_sel_A),   32'(e_sel_a));
        chk("mux_sel_B",   32'(mux_sel_B),   32'(e_sel_b));
        chk("imm_sel",     32'(imm_sel),     32'(e_imm_sel));
        chk("imm",         32'(imm),         32'(e_imm));
        chk("op_ex",       32'(op_ex),       32'(e_op_ex));
    endtask

    // One clock: drive inputs, check, advance model, return at posedge+1.
    task automatic step(input bit v, input logic [31:0] ins);
        bit stall, issue;
        instr_valid = v;
        instr       = ins;
        #1;
        check_all();
        $display("step valid=%0b instr=%08h ready=%0b op_ex=%02h selA=%0d selB=%0d RW_dm=%0d",
                 v, ins, instr_ready, op_ex, mux_sel_A, mux_sel_B, RW_dm);
        stall = m_stall();
        issue = m_id_valid && !stall;
        if (issue) begin
            e_sel_a   = fwd(f_ra(m_id), f_writes(m_id));
            e_sel_b   = fwd(f_rb(m_id), f_reads_b(m_id));
            e_imm_sel = f_imm(m_id);
            e_imm     = m_id[15:0];
            e_op_ex   = f_writes(m_id) ? opc(m_id) : 6'h0;
        end else begin
            e_sel_a   = 2'd0;
            e_sel_b   = 2'd0;
            e_imm_sel = 1'b0;
            e_imm     = 16'h0;
            e_op_ex   = 6'h0;
        end
        m_slot[2] = m_slot[1];
        m_slot[1] = m_slot[0];
        m_slot[0] = issue ? m_id : 32'h0;
        if (v && !stall) begin
            m_id       = ins;
            m_id_valid = 1'b1;
        end else if (issue) begin
            m_id_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0);
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rw,
                                       input logic [4:0] ra, input logic [4:0] rb);
        return {op, rw, ra, rb, 11'h0};
    endfunction
    function automatic logic [31:0] mki(input logic [5:0] op, input logic [4:0] rw,
                                        input logic [4:0] ra, input logic [15:0] im);
        return {op, rw, ra, im};
    endfunction

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Independent R-types
        step(1'b1, mk(6'h01, 5'd1, 5'd2, 5'd3));
        chk("indep_RA0", 32'(RA), 32'd2);
        chk("indep_RB0", 32'(RB), 32'd3);
        step(1'b1, mk(6'h01, 5'd4, 5'd5, 5'd6));
        chk("indep_RA1", 32'(RA), 32'd5);
        chk("indep_RB1", 32'(RB), 32'd6);
        chk("indep_selA", 32'(mux_sel_A), 32'd0);
        idle(2);
        chk("indep_RW_dm", 32'(RW_dm), 32'd1);
        idle(4);

        // Back-to-back dependence, then one and two gaps
        step(1'b1, mk(6'h01, 5'd1, 5'd2, 5'd3));
        step(1'b1, mk(6'h02, 5'd7, 5'd1, 5'd1));
        step(1'b0, 32'h0);
        chk("dep0_selA", 32'(mux_sel_A), 32'd1);
        chk("dep0_selB", 32'(mux_sel_B), 32'd1);
        chk("dep0_op_ex", 32'(op_ex), 32'h02);
        idle(4);
        step(1'b1, mk(6'h01, 5'd1, 5'd2, 5'd3));
        step(1'b1, mk(6'h01, 5'd9, 5'd10, 5'd11));
        step(1'b1, mk(6'h02, 5'd7, 5'd1, 5'd1));
        step(1'b0, 32'h0);
        chk("dep1_selA", 32'(mux_sel_A), 32'd2);
        chk("dep1_selB", 32'(mux_sel_B), 32'd2);
        idle(4);
        step(1'b1, mk(6'h01, 5'd1, 5'd2, 5'd3));
        step(1'b1, mk(6'h01, 5'd9, 5'd10, 5'd11));
        step(1'b1, mk(6'h01, 5'd12, 5'd13, 5'd14));
        step(1'b1, mk(6'h02, 5'd7, 5'd1, 5'd1));
        step(1'b0, 32'h0);
        chk("dep2_selA", 32'(mux_sel_A), 32'd3);
        chk("dep2_selB", 32'(mux_sel_B), 32'd3);
        idle(4);

        // Load-use: one bubble, then forwarded from DM
        step(1'b1, mki(6'h30, 5'd4, 5'd8, 16'h0010));
        step(1'b1, mk(6'h01, 5'd5, 5'd4, 5'd6));
        chk("lu_ready_low", 32'(instr_ready), 32'd0);
        step(1'b0, 32'h0);
        chk("lu_bubble_op_ex", 32'(op_ex), 32'd0);
        chk("lu_ready_back", 32'(instr_ready), 32'd1);
        step(1'b0, 32'h0);
        chk("lu_selA", 32'(mux_sel_A), 32'd2);
        chk("lu_op_ex", 32'(op_ex), 32'h01);
        idle(4);

        // I-type immediate
        step(1'b1, mki(6'h20, 5'd2, 5'd3, 16'hBEEF));
        step(1'b0, 32'h0);
        chk("imm_sel", 32'(imm_sel), 32'd1);
        chk("imm_val", 32'(imm), 32'hBEEF);
        chk("imm_selB", 32'(mux_sel_B), 32'd0);
        chk("imm_op_ex", 32'(op_ex), 32'h20);
        idle(4);

        // Register 0 and undefined opcode are never forwarded
        step(1'b1, mk(6'h01, 5'd0, 5'd2, 5'd3));
        step(1'b1, mk(6'h02, 5'd5, 5'd0, 5'd0));
        step(1'b0, 32'h0);
        chk("r0_selA", 32'(mux_sel_A), 32'd0);
        chk("r0_selB", 32'(mux_sel_B), 32'd0);
        idle(4);
        step(1'b1, mk(6'h3F, 5'd9, 5'd1, 5'd1));
        step(1'b1, mk(6'h01, 5'd5, 5'd9, 5'd9));
        step(1'b0, 32'h0);
        chk("undef_selA", 32'(mux_sel_A), 32'd0);
        chk("undef_selB", 32'(mux_sel_B), 32'd0);
        step(1'b0, 32'h0);
        chk("undef_RW_dm", 32'(RW_dm), 32'd0);
        idle(4);

        // Asynchronous reset with a dependent instruction in ID
        step(1'b1, mk(6'h01, 5'd1, 5'd2, 5'd3));
        step(1'b1, mk(6'h02, 5'd7, 5'd1, 5'd1));
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_op_ex", 32'(op_ex), 32'd0);
        chk("rst_RA", 32'(RA), 32'd0);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, mk(6'h02, 5'd7, 5'd1, 5'd1));
        step(1'b0, 32'h0);
        chk("post_rst_selA", 32'(mux_sel_A), 32'd0);
        chk("post_rst_selB", 32'(mux_sel_B), 32'd0);
        chk("post_rst_op_ex", 32'(op_ex), 32'h02);

        // Randomized stream over a small register set to provoke hazards
        for (int n = 0; n < 300; n++) begin
            logic [5:0]  op;
            logic [31:0] ins;
            int          kind;
            kind = int'($urandom_range(0, 9));
            case (kind)
                0:       op = 6'h00;
                1, 2, 3: op = 6'($urandom_range(1, 31));
                4, 5:    op = 6'($urandom_range(32, 47));
                6, 7:    op = 6'h30;
                8:       op = 6'($urandom_range(49, 63));
                default: op = 6'h01;
            endcase
            ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 11'($urandom)};
            if (n == 150) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all();
                @(negedge clk);
                rst_n = 1'b1;
            end
            step($urandom_range(0, 3) != 0, ins);
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
